frame_writer: RTL and testbench

- Downstream consumer of the camera controller's processed pixel stream.
- Packs pixels into 32-bit words and buffers them in an internal FIFO.
- Writes one frame to SDRAM through a single-word Avalon-MM write master.
- Runs on the pixel clock; signals frame completion and overflow to the host.

---
 rtl/frame_writer.sv | 192 +++++++++++++++++++
 tb/tb_frame_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: takes the processed pixel stream from the camera controller,
// packs it into 32-bit words, buffers the words in a small FIFO and writes one
// frame to SDRAM through a single-word Avalon-MM write master.
//
// Ports:
//   clock, reset_n             pixel clock, asynchronous active-low reset
//   in_start                   start a capture (honoured in IDLE/DONE only)
//   in_base_address            byte address of word 0 (bits [1:0] forced to 0)
//   in_mode                    0 = RGB (one pixel per word), 1 = gray (four per word)
//   in_max_words               word budget for the frame
//   in_valid, in_red/green/blue/gray, in_captured   pixel stream and end of frame
//   avm_*                      Avalon-MM write master
//   out_busy, out_done         CAPTURE/FLUSH and DONE indications
//   out_overflow               sticky: a word was lost to a full FIFO
//   out_word_count             completed memory writes
module frame_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int COUNT_W    = 24
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_start,
  input  logic [31:0]        in_base_address,
  input  logic               in_mode,
  input  logic [COUNT_W-1:0] in_max_words,
  input  logic               in_valid,
  input  logic [9:0]         in_red,
  input  logic [9:0]         in_green,
  input  logic [9:0]         in_blue,
  input  logic [9:0]         in_gray,
  input  logic               in_captured,
  output logic [31:0]        avm_address,
  output logic               avm_write,
  output logic [31:0]        avm_writedata,
  output logic [3:0]         avm_byteenable,
  input  logic               avm_waitrequest,
  output logic               out_busy,
  output logic               out_done,
  output logic               out_overflow,
  output logic [COUNT_W-1:0] out_word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]        base_q;
  logic               mode_q;
  logic [COUNT_W-1:0] max_q;
  logic [COUNT_W-1:0] accepted_q;
  logic [COUNT_W-1:0] word_count_q;
  logic               overflow_q;

  logic [1:0]         pack_cnt, pack_cnt_nxt;
  logic [23:0]        pack_data, pack_data_nxt;

  logic [35:0]        fifo_mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               fifo_empty, fifo_full;
  logic [35:0]        fifo_head;

  logic               word_vld;
  logic [31:0]        word_data;
  logic [3:0]         word_be;
  logic               start_ok, push, drop_full, pop;
  logic [31:0]        count_bytes;

  // Low pixel bits and address bits [1:0] are intentionally discarded.
  logic unused_bits;
  assign unused_bits = ^{in_red[1:0], in_green[1:0], in_blue[1:0], in_gray[1:0],
                         in_base_address[1:0]};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  assign start_ok  = in_start && (state == S_IDLE || state == S_DONE);
  // A word that would exceed the budget is silently discarded; only a word
  // lost to a full FIFO counts as overflow.
  assign push      = word_vld && (accepted_q != max_q) && !fifo_full;
  assign drop_full = word_vld && (accepted_q != max_q) && fifo_full;
  assign pop       = avm_write && !avm_waitrequest;

  // Packer: the incoming pixel is folded in first, then in_captured flushes
  // whatever partial gray word remains. At most one word completes per cycle.
  always_comb begin
    pack_cnt_nxt  = pack_cnt;
    pack_data_nxt = pack_data;
    word_vld      = 1'b0;
    word_data     = 32'h0;
    word_be       = 4'h0;
    if (state == S_CAPTURE) begin
      if (in_valid) begin
        if (!mode_q) begin
          word_vld  = 1'b1;
          word_data = {8'h00, in_red[9:2], in_green[9:2], in_blue[9:2]};
          word_be   = 4'b1111;
        end else if (pack_cnt == 2'd3) begin
          word_vld      = 1'b1;
          word_data     = {in_gray[9:2], pack_data};
          word_be       = 4'b1111;
          pack_cnt_nxt  = 2'd0;
          pack_data_nxt = 24'h0;
        end else begin
          pack_data_nxt[{pack_cnt, 3'b000} +: 8] = in_gray[9:2];
          pack_cnt_nxt  = pack_cnt + 2'd1;
        end
      end
      if (in_captured && pack_cnt_nxt != 2'd0) begin
        word_vld  = 1'b1;
        word_data = {8'h00, pack_data_nxt};
        case (pack_cnt_nxt)
          2'd1:    word_be = 4'b0001;
          2'd2:    word_be = 4'b0011;
          default: word_be = 4'b0111;
        endcase
        pack_cnt_nxt  = 2'd0;
        pack_data_nxt = 24'h0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (in_start)    state_nxt = S_CAPTURE;
      S_CAPTURE:      if (in_captured) state_nxt = S_FLUSH;
      S_FLUSH:        if (fifo_empty)  state_nxt = S_DONE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= 32'h0;
      mode_q       <= 1'b0;
      max_q        <= '0;
      accepted_q   <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      pack_cnt     <= 2'd0;
      pack_data    <= 24'h0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else if (start_ok) begin
      // FIFO is already empty in IDLE/DONE, so pointers need no clearing.
      base_q       <= {in_base_address[31:2], 2'b00};
      mode_q       <= in_mode;
      max_q        <= in_max_words;
      accepted_q   <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      pack_cnt     <= 2'd0;
      pack_data    <= 24'h0;
    end else begin
      pack_cnt  <= pack_cnt_nxt;
      pack_data <= pack_data_nxt;
      if (push) begin
        accepted_q <= accepted_q + COUNT_W'(1);
        wr_ptr     <= wr_ptr + (AW+1)'(1);
      end
      if (drop_full) overflow_q <= 1'b1;
      if (pop) begin
        word_count_q <= word_count_q + COUNT_W'(1);
        rd_ptr       <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // FIFO storage holds data only and is not reset; outputs are gated by empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {word_be, word_data};
  end

  assign count_bytes    = 32'({word_count_q, 2'b00});
  assign avm_write      = !fifo_empty;
  assign avm_address    = base_q + count_bytes;
  assign avm_writedata  = fifo_empty ? 32'h0 : fifo_head[31:0];
  assign avm_byteenable = fifo_empty ? 4'h0  : fifo_head[35:32];

  assign out_busy       = (state == S_CAPTURE) || (state == S_FLUSH);
  assign out_done       = (state == S_DONE);
  assign out_overflow   = overflow_q;
  assign out_word_count = word_count_q;

endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;

  localparam int COUNT_W = 24;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               in_start;
  logic [31:0]        in_base_address;
  logic               in_mode;
  logic [COUNT_W-1:0] in_max_words;
  logic               in_valid;
  logic [9:0]         in_red, in_green, in_blue, in_gray;
  logic               in_captured;
  logic [31:0]        avm_address;
  logic               avm_write;
  logic [31:0]        avm_writedata;
  logic [3:0]         avm_byteenable;
  logic               avm_waitrequest;
  logic               out_busy, out_done, out_overflow;
  logic [COUNT_W-1:0] out_word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wa [0:63];
  logic [31:0] wd [0:63];
  logic [3:0]  wb [0:63];
  int          nwr = 0;
  int          mark;

  frame_writer #(.FIFO_DEPTH(4), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_start(in_start),
    .in_base_address(in_base_address), .in_mode(in_mode), .in_max_words(in_max_words),
    .in_valid(in_valid), .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_gray(in_gray), .in_captured(in_captured),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .out_busy(out_busy), .out_done(out_done), .out_overflow(out_overflow),
    .out_word_count(out_word_count)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after posedge, so a write seen at negedge is the
  // one the slave accepts on the next posedge.
  always @(negedge clock) begin
    if (reset_n && avm_write && !avm_waitrequest && nwr < 64) begin
      wa[nwr] = avm_address;
      wd[nwr] = avm_writedata;
      wb[nwr] = avm_byteenable;
      nwr = nwr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [31:0] base, input logic mode, input logic [COUNT_W-1:0] mx);
    in_start = 1'b1; in_base_address = base; in_mode = mode; in_max_words = mx;
    tick();
    in_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                     input logic [9:0] gy);
    in_valid = 1'b1; in_red = r; in_green = g; in_blue = b; in_gray = gy;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic capture();
    in_captured = 1'b1;
    tick();
    in_captured = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100 && !out_done; i++) tick();
    check(tag, 32'(out_done), 32'h1);
  endtask

  initial begin
    reset_n = 1'b0; in_start = 1'b0; in_base_address = '0; in_mode = 1'b0;
    in_max_words = '0; in_valid = 1'b0; in_red = '0; in_green = '0; in_blue = '0;
    in_gray = '0; in_captured = 1'b0; avm_waitrequest = 1'b0;
    #12;
    check("rst_write", 32'(avm_write), 32'h0);
    check("rst_busy",  32'(out_busy), 32'h0);
    check("rst_done",  32'(out_done), 32'h0);
    check("rst_ovf",   32'(out_overflow), 32'h0);
    check("rst_count", 32'(out_word_count), 32'h0);
    check("rst_addr",  avm_address, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    tick();

    // RGB, four identical pixels
    mark = nwr;
    start(32'h1000, 1'b0, 24'd16);
    check("t1_busy", 32'(out_busy), 32'h1);
    for (int i = 0; i < 4; i++) pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    capture();
    wait_done("t1_done");
    check("t1_nwr", 32'(nwr - mark), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", wa[mark+i], 32'h1000 + 32'(4*i));
      check("t1_data", wd[mark+i], 32'h00FF0180);
      check("t1_be",   32'(wb[mark+i]), 32'hF);
    end
    check("t1_count", 32'(out_word_count), 32'd4);
    check("t1_busy_end", 32'(out_busy), 32'h0);

    // Gray, six pixels leaving a two-byte partial word
    mark = nwr;
    start(32'h3002, 1'b1, 24'd16);
    check("t2_done_clr", 32'(out_done), 32'h0);
    for (int k = 0; k < 6; k++) pix(10'h0, 10'h0, 10'h0, 10'(4*(k+1)));
    capture();
    wait_done("t2_done");
    check("t2_nwr", 32'(nwr - mark), 32'd2);
    check("t2_addr0", wa[mark],   32'h3000);
    check("t2_data0", wd[mark],   32'h04030201);
    check("t2_be0",   32'(wb[mark]), 32'hF);
    check("t2_addr1", wa[mark+1], 32'h3004);
    check("t2_data1", wd[mark+1], 32'h00000605);
    check("t2_be1",   32'(wb[mark+1]), 32'h3);
    check("t2_count", 32'(out_word_count), 32'd2);

    // Stall with 10 pixels into a 4-deep FIFO
    mark = nwr;
    avm_waitrequest = 1'b1;
    start(32'h4000, 1'b0, 24'd16);
    for (int i = 0; i < 10; i++) pix(10'h3FC, 10'h004, 10'(4*i), 10'h0);
    check("t3_ovf",   32'(out_overflow), 32'h1);
    check("t3_write", 32'(avm_write), 32'h1);
    check("t3_addr",  avm_address, 32'h4000);
    check("t3_data",  avm_writedata, 32'h00FF0100);
    capture();
    for (int i = 0; i < 8; i++) tick();
    check("t3_addr_stall", avm_address, 32'h4000);
    check("t3_data_stall", avm_writedata, 32'h00FF0100);
    check("t3_count_stall", 32'(out_word_count), 32'd0);
    avm_waitrequest = 1'b0;
    wait_done("t3_done");
    check("t3_nwr", 32'(nwr - mark), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_waddr", wa[mark+i], 32'h4000 + 32'(4*i));
      check("t3_wdata", wd[mark+i], 32'h00FF0100 + 32'(i));
    end
    check("t3_count", 32'(out_word_count), 32'd4);
    check("t3_ovf_end", 32'(out_overflow), 32'h1);

    // Budget of two words, five pixels
    mark = nwr;
    start(32'h8000, 1'b0, 24'd2);
    check("t4_ovf_clr", 32'(out_overflow), 32'h0);
    for (int i = 0; i < 5; i++) pix(10'h3FC, 10'h004, 10'(4*i), 10'h0);
    capture();
    wait_done("t4_done");
    check("t4_nwr", 32'(nwr - mark), 32'd2);
    check("t4_data1", wd[mark+1], 32'h00FF0101);
    check("t4_ovf", 32'(out_overflow), 32'h0);
    check("t4_count", 32'(out_word_count), 32'd2);

    // Zero budget
    mark = nwr;
    start(32'h9000, 1'b0, 24'd0);
    pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    check("t7_write", 32'(avm_write), 32'h0);
    capture();
    check("t7_flush", 32'(out_busy), 32'h1);
    wait_done("t7_done");
    check("t7_nwr", 32'(nwr - mark), 32'd0);

    // Asynchronous reset with three words queued
    avm_waitrequest = 1'b1;
    start(32'hA000, 1'b0, 24'd16);
    for (int i = 0; i < 3; i++) pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    check("t5_write_pre", 32'(avm_write), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_write", 32'(avm_write), 32'h0);
    check("t5_busy",  32'(out_busy), 32'h0);
    check("t5_count", 32'(out_word_count), 32'h0);
    avm_waitrequest = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    tick();
    check("t5_idle_busy", 32'(out_busy), 32'h0);
    check("t5_idle_done", 32'(out_done), 32'h0);
    mark = nwr;
    start(32'h5000, 1'b0, 24'd16);
    pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    capture();
    wait_done("t5_done");
    check("t5_nwr", 32'(nwr - mark), 32'd1);
    check("t5_addr", wa[mark], 32'h5000);
    check("t5_count_new", 32'(out_word_count), 32'd1);

    // in_start during CAPTURE is ignored
    mark = nwr;
    start(32'h6000, 1'b0, 24'd16);
    pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    start(32'h2000, 1'b0, 24'd16);
    pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    pix(10'h3FC, 10'h004, 10'h200, 10'h0);
    capture();
    wait_done("t6_done");
    check("t6_nwr", 32'(nwr - mark), 32'd4);
    for (int i = 0; i < 4; i++) check("t6_addr", wa[mark+i], 32'h6000 + 32'(4*i));
    check("t6_count", 32'(out_word_count), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
